// File: rtl/hex_parse_pkg.sv
// -----------------------------------------------------------------------------
// hex_parse_pkg
// Shared definitions for the ASCII hex token parser:
//   - parser FSM state encoding
//   - character-class enum produced by the classifier
//   - ASCII constants for the separators and the hex-digit range bounds
// -----------------------------------------------------------------------------
package hex_parse_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TOKEN   = 2'd1,
      S_DISCARD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CLS_DIGIT = 2'd0,
      CLS_SEP   = 2'd1,
      CLS_BAD   = 2'd2
   } char_class_e;

   // Separators
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_COMMA = 8'h2C;

   // Hex digit range bounds
   localparam logic [7:0] ASC_0    = 8'h30;
   localparam logic [7:0] ASC_9    = 8'h39;
   localparam logic [7:0] ASC_UC_A = 8'h41;
   localparam logic [7:0] ASC_UC_F = 8'h46;
   localparam logic [7:0] ASC_LC_A = 8'h61;
   localparam logic [7:0] ASC_LC_F = 8'h66;

   function automatic logic is_separator(input logic [7:0] b);
      return (b == ASC_CR) || (b == ASC_LF) || (b == ASC_SPACE) || (b == ASC_COMMA);
   endfunction

endpackage

// File: rtl/ascii_hex_classify.sv
// -----------------------------------------------------------------------------
// ascii_hex_classify
// Purely combinational classifier for one received ASCII byte.
// Ports:
//   rx_byte_i  in  8  byte to classify
//   cls_o      out    CLS_DIGIT / CLS_SEP / CLS_BAD
//   value_o    out 4  nibble value for CLS_DIGIT, 0 otherwise
// -----------------------------------------------------------------------------
module ascii_hex_classify
   import hex_parse_pkg::*;
(
   input  logic [7:0]  rx_byte_i,
   output char_class_e cls_o,
   output logic [3:0]  value_o
);

   always_comb begin
      cls_o   = CLS_BAD;
      value_o = 4'd0;
      if ((rx_byte_i >= ASC_0) && (rx_byte_i <= ASC_9)) begin
         cls_o   = CLS_DIGIT;
         // '0'..'9' are 0x30..0x39, so the low nibble is the value
         value_o = rx_byte_i[3:0];
      end else if (((rx_byte_i >= ASC_UC_A) && (rx_byte_i <= ASC_UC_F)) ||
                   ((rx_byte_i >= ASC_LC_A) && (rx_byte_i <= ASC_LC_F))) begin
         cls_o   = CLS_DIGIT;
         // 'A'/'a' have low nibble 1, so adding 9 maps them onto 10..15
         value_o = rx_byte_i[3:0] + 4'd9;
      end else if (is_separator(rx_byte_i)) begin
         cls_o   = CLS_SEP;
      end
   end

endmodule

// File: rtl/ascii_hex_parser.sv
// -----------------------------------------------------------------------------
// ascii_hex_parser
// Turns a stream of UART-received ASCII bytes into nibble / terminator beats
// for hex_shifter, limits token length, counts errors and optionally echoes
// every received byte back to the UART transmitter.
// Ports:
//   clk_60mhz   in   1          system clock
//   rst_n       in   1          asynchronous active-low reset
//   rx_data     in   8          byte from UART receiver
//   rx_done     in   1          strobe, rx_data valid this cycle
//   nib_data    out  4          nibble value (0 on terminator beats)
//   nib_valid   out  1          one-cycle beat
//   char_check  out  1          beat is a token terminator
//   digit_cnt   out  3          digits in current token
//   err_pulse   out  1          invalid character or digit overflow
//   err_cnt     out  ERR_CNT_W  saturating error count
//   echo_data   out  8          byte to echo
//   echo_valid  out  1          echo request, held until accepted
//   echo_ready  in   1          transmitter accepts echo
// -----------------------------------------------------------------------------
module ascii_hex_parser
   import hex_parse_pkg::*;
#(
   parameter int MAX_DIGITS = 6,
   parameter bit ECHO_EN    = 1'b1,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk_60mhz,
   input  logic                 rst_n,
   input  logic [7:0]           rx_data,
   input  logic                 rx_done,
   output logic [3:0]           nib_data,
   output logic                 nib_valid,
   output logic                 char_check,
   output logic [2:0]           digit_cnt,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [7:0]           echo_data,
   output logic                 echo_valid,
   input  logic                 echo_ready
);

   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   char_class_e cls;
   logic [3:0]  cls_value;

   state_e                 state_q,      state_d;
   logic [2:0]             digit_cnt_q,  digit_cnt_d;
   logic [3:0]             nib_data_q,   nib_data_d;
   logic                   nib_valid_q,  nib_valid_d;
   logic                   char_check_q, char_check_d;
   logic                   err_pulse_q,  err_pulse_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q,    err_cnt_d;

   ascii_hex_classify u_classify (
      .rx_byte_i (rx_data),
      .cls_o     (cls),
      .value_o   (cls_value)
   );

   // Next-state and beat generation; everything holds unless rx_done is high.
   always_comb begin
      state_d      = state_q;
      digit_cnt_d  = digit_cnt_q;
      nib_data_d   = 4'd0;
      nib_valid_d  = 1'b0;
      char_check_d = 1'b0;
      err_pulse_d  = 1'b0;

      if (rx_done) begin
         case (state_q)
            S_IDLE: begin
               case (cls)
                  CLS_DIGIT: begin
                     nib_valid_d = 1'b1;
                     nib_data_d  = cls_value;
                     digit_cnt_d = 3'd1;
                     state_d     = S_TOKEN;
                  end
                  CLS_SEP: begin
                     // leading / repeated separators produce nothing
                  end
                  default: begin
                     err_pulse_d = 1'b1;
                     state_d     = S_DISCARD;
                  end
               endcase
            end

            S_TOKEN: begin
               case (cls)
                  CLS_DIGIT: begin
                     if (digit_cnt_q < MAX_CNT) begin
                        nib_valid_d = 1'b1;
                        nib_data_d  = cls_value;
                        digit_cnt_d = digit_cnt_q + 3'd1;
                     end else begin
                        // overflow: token is too long, drop rest of it
                        err_pulse_d = 1'b1;
                        state_d     = S_DISCARD;
                     end
                  end
                  CLS_SEP: begin
                     nib_valid_d  = 1'b1;
                     char_check_d = 1'b1;
                     digit_cnt_d  = 3'd0;
                     state_d      = S_IDLE;
                  end
                  default: begin
                     err_pulse_d = 1'b1;
                     state_d     = S_DISCARD;
                  end
               endcase
            end

            S_DISCARD: begin
               if (cls == CLS_SEP) begin
                  // terminator lets downstream close any partial token
                  nib_valid_d  = 1'b1;
                  char_check_d = 1'b1;
                  digit_cnt_d  = 3'd0;
                  state_d      = S_IDLE;
               end
            end

            default: begin
               state_d     = S_IDLE;
               digit_cnt_d = 3'd0;
            end
         endcase
      end
   end

   // Saturating error counter, advanced together with err_pulse.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_pulse_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_60mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         digit_cnt_q  <= 3'd0;
         nib_data_q   <= 4'd0;
         nib_valid_q  <= 1'b0;
         char_check_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         digit_cnt_q  <= digit_cnt_d;
         nib_data_q   <= nib_data_d;
         nib_valid_q  <= nib_valid_d;
         char_check_q <= char_check_d;
         err_pulse_q  <= err_pulse_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign nib_data   = nib_data_q;
   assign nib_valid  = nib_valid_q;
   assign char_check = char_check_q;
   assign digit_cnt  = digit_cnt_q;
   assign err_pulse  = err_pulse_q;
   assign err_cnt    = err_cnt_q;

   if (ECHO_EN) begin : g_echo
      logic [7:0] echo_data_q,  echo_data_d;
      logic       echo_valid_q, echo_valid_d;

      // A new byte always wins: it overwrites an unaccepted one and keeps
      // echo_valid high even when the old byte is accepted this cycle.
      always_comb begin
         echo_data_d  = echo_data_q;
         echo_valid_d = echo_valid_q;
         if (rx_done) begin
            echo_data_d  = rx_data;
            echo_valid_d = 1'b1;
         end else if (echo_valid_q && echo_ready) begin
            echo_valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk_60mhz or negedge rst_n) begin
         if (!rst_n) begin
            echo_data_q  <= 8'd0;
            echo_valid_q <= 1'b0;
         end else begin
            echo_data_q  <= echo_data_d;
            echo_valid_q <= echo_valid_d;
         end
      end

      assign echo_data  = echo_data_q;
      assign echo_valid = echo_valid_q;
   end else begin : g_no_echo
      logic unused_echo_ready;
      assign unused_echo_ready = echo_ready;
      assign echo_data  = 8'd0;
      assign echo_valid = 1'b0;
   end

endmodule

// File: tb/tb_ascii_hex_parser.sv
module tb_ascii_hex_parser;

   logic       clk_60mhz = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [3:0] nib_data;
   logic       nib_valid;
   logic       char_check;
   logic [2:0] digit_cnt;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic [7:0] echo_data;
   logic       echo_valid;
   logic       echo_ready;

   ascii_hex_parser #(.MAX_DIGITS(6), .ECHO_EN(1'b1), .ERR_CNT_W(8)) dut (
      .clk_60mhz  (clk_60mhz),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .nib_data   (nib_data),
      .nib_valid  (nib_valid),
      .char_check (char_check),
      .digit_cnt  (digit_cnt),
      .err_pulse  (err_pulse),
      .err_cnt    (err_cnt),
      .echo_data  (echo_data),
      .echo_valid (echo_valid),
      .echo_ready (echo_ready)
   );

   always #8 clk_60mhz = ~clk_60mhz;

   typedef struct {
      bit       is_err;
      bit       term;
      int       data;
   } ev_t;

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;

   // Reference model: token length, "broken token" flag, error count.
   int  m_len    = 0;
   bit  m_broken = 0;
   int  m_err    = 0;

   string HEX_LO = "0123456789abcdef";
   string HEX_UP = "0123456789ABCDEF";
   string SEPS   = "\r\n ,";

   function automatic int hex_value(input logic [7:0] b);
      for (int i = 0; i < 16; i++) begin
         if (b == HEX_LO[i] || b == HEX_UP[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit is_sep(input logic [7:0] b);
      for (int i = 0; i < SEPS.len(); i++) begin
         if (b == SEPS[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic push_err();
      ev_t e;
      e.is_err = 1; e.term = 0; e.data = 0;
      exp_q.push_back(e);
      if (m_err < 255) m_err++;
      m_broken = 1;
   endtask

   task automatic push_beat(input bit term, input int val);
      ev_t e;
      e.is_err = 0; e.term = term; e.data = val;
      exp_q.push_back(e);
   endtask

   task automatic model_byte(input logic [7:0] b);
      int v;
      v = hex_value(b);
      if (v >= 0) begin
         if (!m_broken) begin
            if (m_len < 6) begin
               push_beat(0, v);
               m_len++;
            end else begin
               push_err();
            end
         end
      end else if (is_sep(b)) begin
         if (m_len > 0 || m_broken) push_beat(1, 0);
         m_len = 0;
         m_broken = 0;
      end else if (!m_broken) begin
         push_err();
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expected event per observed beat/error.
   always @(negedge clk_60mhz) begin
      ev_t e;
      if (rst_n) begin
         if (nib_valid || err_pulse) begin
            if (nib_valid && err_pulse) begin
               check("beat_and_err_together", 1, 0);
            end else if (exp_q.size() == 0) begin
               check("unexpected_event_nib_valid", int'(nib_valid), 0);
            end else begin
               e = exp_q.pop_front();
               if (e.is_err) begin
                  check("err_pulse", int'(err_pulse), 1);
               end else begin
                  check("nib_valid", int'(nib_valid), 1);
                  check("nib_data", int'(nib_data), e.data);
                  check("char_check", int'(char_check), int'(e.term));
               end
            end
         end else if (char_check) begin
            check("char_check_without_beat", int'(char_check), 0);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      @(negedge clk_60mhz);
      rx_data = b;
      rx_done = 1'b1;
      model_byte(b);
      @(negedge clk_60mhz);
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      #1;
      check("queue_drained", exp_q.size(), 0);
      check("digit_cnt", int'(digit_cnt), m_len);
      check("err_cnt", int'(err_cnt), m_err);
      check("echo_valid_after_rx", int'(echo_valid), 1);
      check("echo_data", int'(echo_data), int'(b));
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_nib_valid"}, int'(nib_valid), 0);
      check({tag, "_nib_data"}, int'(nib_data), 0);
      check({tag, "_char_check"}, int'(char_check), 0);
      check({tag, "_digit_cnt"}, int'(digit_cnt), 0);
      check({tag, "_err_pulse"}, int'(err_pulse), 0);
      check({tag, "_err_cnt"}, int'(err_cnt), 0);
      check({tag, "_echo_valid"}, int'(echo_valid), 0);
      check({tag, "_echo_data"}, int'(echo_data), 0);
   endtask

   // Asynchronous reset, asserted mid-cycle away from the clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk_60mhz);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      m_len = 0; m_broken = 0; m_err = 0;
      #2;
      check_all_zero(tag);
      @(negedge clk_60mhz);
      rst_n = 1'b1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] bounds [12];
      rst_n      = 1'b0;
      rx_done    = 1'b0;
      rx_data    = 8'h00;
      echo_ready = 1'b0;
      #20;
      check_all_zero("reset");
      @(negedge clk_60mhz);
      rst_n = 1'b1;

      send_str("1A2b\r");

      do_reset("rst1");
      send_str("\r\n  5 ");

      do_reset("rst2");
      send_str("1234567 ");
      check("overflow_err_cnt", int'(err_cnt), 1);

      do_reset("rst3");
      send_str("12G3 ");
      check("bad_char_err_cnt", int'(err_cnt), 1);

      // Echo holding register
      do_reset("rst4");
      echo_ready = 1'b0;
      send("A");
      send("B");
      @(negedge clk_60mhz);
      #1;
      check("echo_hold_valid", int'(echo_valid), 1);
      check("echo_hold_data", int'(echo_data), 8'h42);
      echo_ready = 1'b1;
      @(negedge clk_60mhz);
      echo_ready = 1'b0;
      #1;
      check("echo_cleared", int'(echo_valid), 0);
      echo_ready = 1'b1;
      send("C");
      echo_ready = 1'b0;
      send(" ");

      // Reset mid-token: no terminator for "12"
      do_reset("rst5");
      send_str("12");
      do_reset("rst6");
      send_str("3 ");

      // Classification boundaries, each followed by a separator
      bounds = '{8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67,
                 8'h30, 8'h39, 8'h41, 8'h46, 8'h61, 8'h66};
      for (int i = 0; i < 12; i++) begin
         send(bounds[i]);
         send(",");
      end
      send_str("09AFaf\n");

      // Random traffic with idle gaps and random echo_ready
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: b = HEX_UP[$urandom_range(0, 15)];
            4:          b = HEX_LO[$urandom_range(0, 15)];
            5, 6:       b = SEPS[$urandom_range(0, 3)];
            default:    b = 8'($urandom);
         endcase
         echo_ready = 1'($urandom);
         send(b);
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            echo_ready = 1'($urandom);
            @(negedge clk_60mhz);
         end
      end
      echo_ready = 1'b0;

      // Error counter saturation
      do_reset("rst7");
      for (int i = 0; i < 300; i++) begin
         send("G");
         send(" ");
      end
      check("err_cnt_saturated", int'(err_cnt), 255);

      repeat (3) @(negedge clk_60mhz);
      check("final_queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
